// File: rtl/ct_lsu_dcache_pkg.sv
// ct_lsu_dcache_pkg: shared types and constants for the dcache state-array writer.
// Holds the request type encodings, the dirty-array bit layout, the writer FSM
// states and the packed request entry that is queued ahead of the array port.
package ct_lsu_dcache_pkg;

  localparam int PA_W    = 40;  // physical address width
  localparam int IDX_LSB = 6;   // set index starts above the 64B line offset

  typedef enum logic [1:0] {
    REQ_REFILL    = 2'd0,
    REQ_SET_DIRTY = 2'd1,
    REQ_INVALID   = 2'd2,
    REQ_SW_CLEAN  = 2'd3
  } req_type_e;

  // Dirty-array layout: one {d,s,v} triple per way, LRU bit on top.
  localparam int DIRTY_V    = 0;
  localparam int DIRTY_S    = 1;
  localparam int DIRTY_D    = 2;
  localparam int WAY_STRIDE = 3;
  localparam int DIRTY_LRU  = 6;
  localparam int DIRTY_W    = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    WR   = 2'd2
  } state_e;

  typedef struct packed {
    req_type_e         typ;
    logic [PA_W-1:0]   addr;
    logic              way;
    logic              dirty;
    logic              share;
  } req_t;

endpackage

// File: rtl/ct_lsu_dcache_state_enc.sv
// ct_lsu_dcache_state_enc: encodes one queued request into tag/dirty array write controls.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the outputs with its write strobe.
// Ports: i_req (head entry) -> o_idx, o_tag_gwen/wen/din, o_dirty_wen/din, o_sw_inst.
// Optional feature: define CT_LSU_DCSW_LRU_UPDATE_EN to make every write also
// point the LRU bit at the way that was not written.
module ct_lsu_dcache_state_enc
  import ct_lsu_dcache_pkg::*;
#(
  parameter int IDX_W = 9,
  parameter int TAG_W = 26
) (
  input  req_t                 i_req,
  output logic [IDX_W-1:0]     o_idx,
  output logic                 o_tag_gwen,
  output logic [1:0]           o_tag_wen,
  output logic [2*TAG_W-1:0]   o_tag_din,
  output logic [DIRTY_W-1:0]   o_dirty_wen,
  output logic [DIRTY_W-1:0]   o_dirty_din,
  output logic                 o_sw_inst
);

  logic [TAG_W-1:0] w_tag;
  logic             w_unused;

  assign w_tag    = i_req.addr[PA_W-1 -: TAG_W];
  assign o_idx    = i_req.addr[IDX_LSB +: IDX_W];
  assign w_unused = ^i_req.addr[IDX_LSB-1:0];

  always_comb begin
    o_tag_gwen  = 1'b0;
    o_tag_wen   = 2'b00;
    o_tag_din   = '0;
    o_dirty_wen = '0;
    o_dirty_din = '0;
    o_sw_inst   = 1'b0;

    for (int w = 0; w < 2; w++) begin
      if (i_req.way == 1'(w)) begin
        case (i_req.typ)
          REQ_REFILL: begin
            o_tag_gwen = 1'b1;
            o_tag_wen[w] = 1'b1;
            o_tag_din = {w_tag, w_tag};
            o_dirty_wen[w*WAY_STRIDE +: 3] = 3'b111;
            o_dirty_din[w*WAY_STRIDE + DIRTY_D] = i_req.dirty;
            o_dirty_din[w*WAY_STRIDE + DIRTY_S] = i_req.share;
            o_dirty_din[w*WAY_STRIDE + DIRTY_V] = 1'b1;
          end
          REQ_SET_DIRTY: begin
            o_dirty_wen[w*WAY_STRIDE + DIRTY_D] = 1'b1;
            o_dirty_din[w*WAY_STRIDE + DIRTY_D] = 1'b1;
          end
          REQ_INVALID: begin
            o_dirty_wen[w*WAY_STRIDE +: 3] = 3'b111;
          end
          default: begin
            // set&way clean only clears the dirty bit of the chosen way
            o_dirty_wen[w*WAY_STRIDE + DIRTY_D] = 1'b1;
            o_sw_inst = 1'b1;
          end
        endcase
      end
    end

`ifdef CT_LSU_DCSW_LRU_UPDATE_EN
    o_dirty_wen[DIRTY_LRU] = 1'b1;
    o_dirty_din[DIRTY_LRU] = ~i_req.way;
`else
    o_dirty_wen[DIRTY_LRU] = 1'b0;
    o_dirty_din[DIRTY_LRU] = 1'b0;
`endif
  end

endmodule

// File: rtl/ct_lsu_fifo.sv
// ct_lsu_fifo: generic in-order FIFO with registered full/empty flags.
// Latency: a push is visible at the head the cycle after it is accepted.
// Backpressure: o_push_rdy = !full (registered); pushes while full are dropped.
// Ports: clk/rst (sync, active-high), push side (vld/dat/rdy), pop side
// (pop strobe, head data, head valid), and current occupancy.
module ct_lsu_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push_vld,
  input  logic [WIDTH-1:0]           i_push_dat,
  output logic                       o_push_rdy,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_pop_dat,
  output logic                       o_pop_vld,
  output logic [$clog2(DEPTH):0]     o_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_cnt;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;
  logic [CW-1:0]    w_cnt_nxt;

  assign w_push    = i_push_vld && !r_full;
  assign w_pop     = i_pop && !r_empty;
  assign w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == CW'(DEPTH));
      r_empty <= (w_cnt_nxt == '0);
    end
  end

  // Storage carries no reset; validity is tracked by the pointers/flags.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_push_dat;
  end

  assign o_push_rdy = !r_full;
  assign o_pop_dat  = r_mem[r_rptr];
  assign o_pop_vld  = !r_empty;
  assign o_cnt      = r_cnt;

endmodule

// File: rtl/ct_lsu_dcache_state_wr.sv
// ct_lsu_dcache_state_wr: queues dcache state changes and writes them to the tag/dirty arrays.
// Latency: push in N -> wr_req in N+1 -> array write in N+2 with immediate grant.
// Backpressure: req_rdy = FIFO not full (registered); wr_req held until wr_grnt.
// Ports: forever_cpuclk/cpurst (sync, active-high); req_* request side;
// wr_req/wr_grnt array arbitration; dcache_* array write controls; wr_done pulse.
// Optional feature: CT_LSU_DCSW_LRU_UPDATE_EN (LRU update on every write).
module ct_lsu_dcache_state_wr
  import ct_lsu_dcache_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int IDX_W = 9,
  parameter int TAG_W = 26
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst,
  input  logic                 req_vld,
  output logic                 req_rdy,
  input  logic [1:0]           req_type,
  input  logic [PA_W-1:0]      req_addr,
  input  logic                 req_way,
  input  logic                 req_dirty,
  input  logic                 req_share,
  output logic                 wr_req,
  input  logic                 wr_grnt,
  output logic [IDX_W-1:0]     dcache_idx,
  output logic                 dcache_tag_gwen,
  output logic [1:0]           dcache_tag_wen,
  output logic [2*TAG_W-1:0]   dcache_tag_din,
  output logic                 dcache_dirty_gwen,
  output logic [DIRTY_W-1:0]   dcache_dirty_wen,
  output logic [DIRTY_W-1:0]   dcache_dirty_din,
  output logic                 dcache_sw_inst,
  output logic                 wr_done
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e               r_state;
  state_e               w_state_nxt;
  req_t                 w_push_dat;
  req_t                 w_head;
  logic                 w_head_vld;
  logic                 w_fifo_rdy;
  logic                 w_push;
  logic                 w_wr;
  logic                 w_drv;
  logic                 w_more;
  logic [CW-1:0]        w_fifo_cnt;
  logic [IDX_W-1:0]     w_enc_idx;
  logic                 w_enc_tag_gwen;
  logic [1:0]           w_enc_tag_wen;
  logic [2*TAG_W-1:0]   w_enc_tag_din;
  logic [DIRTY_W-1:0]   w_enc_dirty_wen;
  logic [DIRTY_W-1:0]   w_enc_dirty_din;
  logic                 w_enc_sw_inst;

  assign w_push_dat = '{typ: req_type_e'(req_type), addr: req_addr, way: req_way,
                        dirty: req_dirty, share: req_share};
  assign w_push     = req_vld && w_fifo_rdy;

  ct_lsu_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (forever_cpuclk),
    .rst        (cpurst),
    .i_push_vld (req_vld),
    .i_push_dat (w_push_dat),
    .o_push_rdy (w_fifo_rdy),
    .i_pop      (w_wr),
    .o_pop_dat  (w_head),
    .o_pop_vld  (w_head_vld),
    .o_cnt      (w_fifo_cnt)
  );

  ct_lsu_dcache_state_enc #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_enc (
    .i_req       (w_head),
    .o_idx       (w_enc_idx),
    .o_tag_gwen  (w_enc_tag_gwen),
    .o_tag_wen   (w_enc_tag_wen),
    .o_tag_din   (w_enc_tag_din),
    .o_dirty_wen (w_enc_dirty_wen),
    .o_dirty_din (w_enc_dirty_din),
    .o_sw_inst   (w_enc_sw_inst)
  );

  // Something is still queued once the head is popped this cycle.
  assign w_more = (w_fifo_cnt > CW'(1)) || w_push;

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // IDLE requests the port itself so a fresh push reaches wr_req one cycle later.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_head_vld) w_state_nxt = wr_grnt ? WR : ARB;
      ARB:     if (wr_grnt)    w_state_nxt = WR;
      WR:      w_state_nxt = w_more ? ARB : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Reset gates everything so an in-progress write is dropped in the same cycle.
  always_comb begin
    w_wr  = (r_state == WR) && !cpurst;
    w_drv = w_head_vld && !cpurst;

    wr_req            = !cpurst && w_head_vld && (r_state == IDLE || r_state == ARB);
    wr_done           = w_wr;
    dcache_dirty_gwen = w_wr;
    dcache_tag_gwen   = w_wr && w_enc_tag_gwen;
    dcache_tag_wen    = w_wr ? w_enc_tag_wen   : '0;
    dcache_dirty_wen  = w_wr ? w_enc_dirty_wen : '0;
    dcache_sw_inst    = w_wr && w_enc_sw_inst;
    dcache_idx        = w_drv ? w_enc_idx       : '0;
    dcache_tag_din    = w_drv ? w_enc_tag_din   : '0;
    dcache_dirty_din  = w_drv ? w_enc_dirty_din : '0;
  end

  assign req_rdy = w_fifo_rdy;

endmodule

// File: tb/tb_ct_lsu_dcache_state_wr.sv
module tb_ct_lsu_dcache_state_wr;

  localparam int DEPTH = 2;

`ifdef CT_LSU_DCSW_LRU_UPDATE_EN
  localparam logic [6:0] LRU0_WEN = 7'h40, LRU0_DIN = 7'h40;
  localparam logic [6:0] LRU1_WEN = 7'h40, LRU1_DIN = 7'h00;
`else
  localparam logic [6:0] LRU0_WEN = 7'h00, LRU0_DIN = 7'h00;
  localparam logic [6:0] LRU1_WEN = 7'h00, LRU1_DIN = 7'h00;
`endif

  logic        clk = 1'b0;
  logic        cpurst = 1'b1;
  logic        req_vld = 1'b0;
  logic        req_rdy;
  logic [1:0]  req_type = 2'd0;
  logic [39:0] req_addr = 40'd0;
  logic        req_way = 1'b0;
  logic        req_dirty = 1'b0;
  logic        req_share = 1'b0;
  logic        wr_req;
  logic        wr_grnt = 1'b0;
  logic [8:0]  dcache_idx;
  logic        dcache_tag_gwen;
  logic [1:0]  dcache_tag_wen;
  logic [51:0] dcache_tag_din;
  logic        dcache_dirty_gwen;
  logic [6:0]  dcache_dirty_wen;
  logic [6:0]  dcache_dirty_din;
  logic        dcache_sw_inst;
  logic        wr_done;

  always #5 clk = ~clk;

  ct_lsu_dcache_state_wr #(.DEPTH(DEPTH), .IDX_W(9), .TAG_W(26)) dut (
    .forever_cpuclk    (clk),
    .cpurst            (cpurst),
    .req_vld           (req_vld),
    .req_rdy           (req_rdy),
    .req_type          (req_type),
    .req_addr          (req_addr),
    .req_way           (req_way),
    .req_dirty         (req_dirty),
    .req_share         (req_share),
    .wr_req            (wr_req),
    .wr_grnt           (wr_grnt),
    .dcache_idx        (dcache_idx),
    .dcache_tag_gwen   (dcache_tag_gwen),
    .dcache_tag_wen    (dcache_tag_wen),
    .dcache_tag_din    (dcache_tag_din),
    .dcache_dirty_gwen (dcache_dirty_gwen),
    .dcache_dirty_wen  (dcache_dirty_wen),
    .dcache_dirty_din  (dcache_dirty_din),
    .dcache_sw_inst    (dcache_sw_inst),
    .wr_done           (wr_done)
  );

  // Reference model: pending requests in order, plus whether a granted write lands this cycle.
  typedef struct {
    logic [1:0]  typ;
    logic [39:0] addr;
    logic        way;
    logic        d;
    logic        s;
  } mreq_t;

  mreq_t q[$];
  bit    wr_now = 1'b0;
  int    n_chk = 0;
  int    n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Expected array controls for one request, straight from the per-type rules.
  task automatic expect_enc(input mreq_t r, output logic [1:0] twen, output logic [51:0] tdin,
                            output logic [6:0] dwen, output logic [6:0] ddin, output logic sw);
    int b;
    logic [6:0] tri3;
    b = 3 * int'(r.way);
    twen = 2'b00; tdin = '0; dwen = '0; ddin = '0; sw = 1'b0;
    case (r.typ)
      2'd0: begin
        twen = r.way ? 2'b10 : 2'b01;
        tdin = {r.addr[39:14], r.addr[39:14]};
        dwen = 7'b0000111 << b;
        tri3 = {4'b0000, r.d, r.s, 1'b1};
        ddin = tri3 << b;
      end
      2'd1: begin dwen = 7'b0000100 << b; ddin = 7'b0000100 << b; end
      2'd2: begin dwen = 7'b0000111 << b; end
      default: begin dwen = 7'b0000100 << b; sw = 1'b1; end
    endcase
`ifdef CT_LSU_DCSW_LRU_UPDATE_EN
    dwen[6] = 1'b1;
    ddin[6] = ~r.way;
`endif
  endtask

  // One clock: drive inputs after the edge, check at the falling edge, advance the model.
  task automatic step(input logic vld, input logic [1:0] typ, input logic [39:0] addr,
                      input logic way, input logic d, input logic s,
                      input logic grnt, input logic rst_i);
    bit exp_rdy, exp_wr, exp_req, push;
    logic [1:0] twen; logic [51:0] tdin; logic [6:0] dwen, ddin; logic sw;
    mreq_t nr;
    @(posedge clk);
    #1;
    cpurst = rst_i; req_vld = vld; req_type = typ; req_addr = addr;
    req_way = way; req_dirty = d; req_share = s; wr_grnt = grnt;
    @(negedge clk);
    exp_rdy = (q.size() < DEPTH);
    exp_wr  = wr_now && !rst_i;
    exp_req = !rst_i && !wr_now && (q.size() > 0);
    chk("req_rdy", 64'(req_rdy), 64'(exp_rdy));
    chk("wr_req", 64'(wr_req), 64'(exp_req));
    chk("wr_done", 64'(wr_done), 64'(exp_wr));
    chk("dirty_gwen", 64'(dcache_dirty_gwen), 64'(exp_wr));
    if (exp_wr) begin
      expect_enc(q[0], twen, tdin, dwen, ddin, sw);
      chk("idx", 64'(dcache_idx), 64'(q[0].addr[14:6]));
      chk("tag_gwen", 64'(dcache_tag_gwen), 64'(q[0].typ == 2'd0));
      chk("tag_wen", 64'(dcache_tag_wen), 64'(twen));
      if (q[0].typ == 2'd0) chk("tag_din", 64'(dcache_tag_din), 64'(tdin));
      chk("dirty_wen", 64'(dcache_dirty_wen), 64'(dwen));
      chk("dirty_din", 64'(dcache_dirty_din), 64'(ddin));
      chk("sw_inst", 64'(dcache_sw_inst), 64'(sw));
    end else begin
      chk("idle_tag_gwen", 64'(dcache_tag_gwen), 64'd0);
      chk("idle_tag_wen", 64'(dcache_tag_wen), 64'd0);
      chk("idle_dirty_wen", 64'(dcache_dirty_wen), 64'd0);
      chk("idle_sw_inst", 64'(dcache_sw_inst), 64'd0);
    end
    if (rst_i) begin
      q.delete();
      wr_now = 1'b0;
    end else begin
      push = vld && exp_rdy;
      if (exp_wr) void'(q.pop_front());
      if (push) begin
        nr.typ = typ; nr.addr = addr; nr.way = way; nr.d = d; nr.s = s;
        q.push_back(nr);
      end
      wr_now = exp_req && grnt;
    end
  endtask

  task automatic idle(input logic grnt);
    step(1'b0, 2'd0, 40'd0, 1'b0, 1'b0, 1'b0, grnt, 1'b0);
  endtask

  initial begin
    // Reset and reset state
    step(1'b0, 2'd0, 40'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 2'd0, 40'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    chk("rst_rdy", 64'(req_rdy), 64'd1);
    chk("rst_wr_req", 64'(wr_req), 64'd0);
    chk("rst_gwen", 64'({dcache_tag_gwen, dcache_dirty_gwen}), 64'd0);

    // REFILL way1, immediate grant
    step(1'b1, 2'd0, 40'h12_3456_7840, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    chk("t1_wr_req", 64'(wr_req), 64'd1);
    idle(1'b0);
    chk("t1_idx", 64'(dcache_idx), 64'h1E1);
    chk("t1_tag_wen", 64'(dcache_tag_wen), 64'h2);
    chk("t1_dirty_wen", 64'(dcache_dirty_wen), 64'(7'h38 | LRU1_WEN));
    chk("t1_dirty_din", 64'(dcache_dirty_din), 64'(7'h18 | LRU1_DIN));
    chk("t1_wr_done", 64'(wr_done), 64'd1);
    idle(1'b0);
    chk("t1_done_pulse", 64'(wr_done), 64'd0);

    // REFILL way0: LRU bit behaviour
    step(1'b1, 2'd0, 40'hAB_CDEF_0123, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b0);
    chk("lru_wen6", 64'(dcache_dirty_wen[6]), 64'(LRU0_WEN[6]));
    chk("lru_din6", 64'(dcache_dirty_din[6]), 64'(LRU0_DIN[6]));

    // SET_DIRTY way0, grant withheld 3 cycles
    step(1'b1, 2'd1, 40'h00_0000_1240, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      chk("t2_wr_req_hold", 64'(wr_req), 64'd1);
    end
    idle(1'b1);
    idle(1'b0);
    chk("t2_dirty_wen", 64'(dcache_dirty_wen), 64'(7'h04 | LRU0_WEN));
    chk("t2_dirty_din", 64'(dcache_dirty_din), 64'(7'h04 | LRU0_DIN));
    chk("t2_tag_gwen", 64'(dcache_tag_gwen), 64'd0);
    idle(1'b0);

    // Three back-to-back requests into a 2-deep queue
    step(1'b1, 2'd2, 40'h11_1111_1100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 2'd1, 40'h22_2222_2200, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_rdy_2nd", 64'(req_rdy), 64'd1);
    step(1'b1, 2'd3, 40'h33_3333_3300, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_full", 64'(req_rdy), 64'd0);
    chk("t3_first_write", 64'(wr_done), 64'd1);
    step(1'b1, 2'd3, 40'h33_3333_3300, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_third_accepted", 64'(req_rdy), 64'd1);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // INVALID way1 then SW_CLEAN way0
    step(1'b1, 2'd2, 40'h44_4444_4440, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd3, 40'h55_5555_5540, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    chk("t4_inv_wen", 64'(dcache_dirty_wen), 64'(7'h38 | LRU1_WEN));
    chk("t4_inv_din", 64'(dcache_dirty_din), 64'(LRU1_DIN));
    chk("t4_inv_sw", 64'(dcache_sw_inst), 64'd0);
    idle(1'b1);
    idle(1'b0);
    chk("t4_sw_wen", 64'(dcache_dirty_wen), 64'(7'h04 | LRU0_WEN));
    chk("t4_sw_din", 64'(dcache_dirty_din), 64'(LRU0_DIN));
    chk("t4_sw_inst", 64'(dcache_sw_inst), 64'd1);
    idle(1'b0);

    // Reset while arbitrating with two entries queued
    step(1'b1, 2'd0, 40'h66_6666_6640, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'd1, 40'h77_7777_7740, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'd0, 40'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    chk("t5_no_gwen", 64'({dcache_tag_gwen, dcache_dirty_gwen}), 64'd0);
    chk("t5_rdy", 64'(req_rdy), 64'd1);
    chk("t5_no_req", 64'(wr_req), 64'd0);
    idle(1'b1);
    chk("t5_still_idle", 64'({wr_req, dcache_dirty_gwen}), 64'd0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           {8'($urandom), 32'($urandom)}, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 199) == 0));
    end
    for (int i = 0; i < 8; i++) idle(1'b1);
    chk("drain_empty", 64'(q.size()), 64'd0);
    chk("drain_rdy", 64'(req_rdy), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
